// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared definitions for the FIFO read-side serial transmitter.
//   - DATA_W          : byte width moved from the FIFO to the serial line
//   - FIFO_EMPTY_BYTE : value the FIFO presents on data_out when it has nothing to give
//   - tx_state_t      : transmitter FSM states
//                       (IDLE=0, REQ=1, CAP=2, START=3, DATA=4, STOP=5)
//   - is_empty_read   : classifies a captured read as "FIFO empty"
package fifo_pkg;

  localparam int                DATA_W          = 8;
  localparam logic [DATA_W-1:0] FIFO_EMPTY_BYTE = 8'h00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    CAP   = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } tx_state_t;

  // The FIFO never stores a zero byte, so a zero on data_out is an empty read.
  // The sticky underflow flag is also treated as empty.
  function automatic logic is_empty_read(input logic [DATA_W-1:0] data,
                                         input logic              underflow);
    return (data == FIFO_EMPTY_BYTE) || underflow;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// baud_tick_gen
//   Per-bit cycle counter for the serial transmitter.
//   Ports:
//     clk     in  1  clock, posedge
//     reset   in  1  synchronous, active-low
//     run     in  1  count while high; held at 0 while low
//     clear   in  1  restart the count at 0 on the next edge (state entry)
//     bit_end out 1  high in the last cycle of each bit period (count == CLKS_PER_BIT-1)
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic bit_end
);

  localparam int                CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_reg;

  assign bit_end = run && (count_reg == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear || !run || bit_end) begin
      // Wrap at the terminal count; never counts past CLKS_PER_BIT-1.
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Pulls bytes from the FIFO read port and sends each one as a serial frame:
//   1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
//   Ports:
//     clk            in   1  clock, posedge
//     reset          in   1  synchronous, active-low
//     tx_enable      in   1  permission to fetch and send bytes
//     fifo_data      in   8  FIFO data_out, valid the cycle after fifo_rd_en
//     fifo_underflow in   1  FIFO sticky underflow flag (treated as empty)
//     fifo_rd_en     out  1  single-cycle read request
//     tx             out  1  serial line, registered, idles high
//     tx_busy        out  1  high from fetch request to end of stop bit
//     frame_done     out  1  pulse in the last cycle of each stop bit
//     empty_seen     out  1  pulse when a fetch comes back empty
module fifo_uart_tx
  import fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int POLL_GAP     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_enable,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_underflow,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              tx_busy,
  output logic              frame_done,
  output logic              empty_seen
);

  localparam int POLL_W = $clog2(POLL_GAP + 1);

  tx_state_t         state_reg, state_next;
  logic [POLL_W-1:0] poll_reg, poll_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [2:0]        bit_idx_reg, bit_idx_next;
  logic              tx_reg, tx_next;
  logic              bit_end;
  logic              baud_run;
  logic              baud_clear;

  assign baud_run   = (state_reg == START) || (state_reg == DATA) || (state_reg == STOP);
  assign baud_clear = (state_next != state_reg);

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .run     (baud_run),
    .clear   (baud_clear),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      poll_reg    <= '0;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      poll_reg    <= poll_next;
      shift_reg   <= shift_next;
      bit_idx_reg <= bit_idx_next;
      tx_reg      <= tx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    poll_next    = poll_reg;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx_reg;
    fifo_rd_en   = 1'b0;
    frame_done   = 1'b0;
    empty_seen   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // poll_reg holds the number of idle cycles still owed, counting the
        // current one, so an empty read is followed by exactly POLL_GAP idle
        // cycles before the next request.
        if (tx_enable && (poll_reg <= POLL_W'(1))) begin
          state_next = REQ;
        end
        if (poll_reg != '0) begin
          poll_next = poll_reg - POLL_W'(1);
        end
      end

      REQ: begin
        fifo_rd_en = 1'b1;
        state_next = CAP;
      end

      CAP: begin
        if (is_empty_read(fifo_data, fifo_underflow)) begin
          empty_seen = 1'b1;
          poll_next  = POLL_W'(POLL_GAP);
          state_next = IDLE;
        end else begin
          shift_next   = fifo_data;
          bit_idx_next = '0;
          state_next   = START;
        end
      end

      START: begin
        if (bit_end) begin
          state_next = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == 3'd7) begin
            bit_idx_next = '0;
            state_next   = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end

      STOP: begin
        if (bit_end) begin
          frame_done = 1'b1;
          state_next = tx_enable ? REQ : IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The line level is derived from the upcoming state so tx is a flop that
  // lines up cycle-for-cycle with state_reg.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign tx      = tx_reg;
  assign tx_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
//   Directed and randomized checks of fifo_uart_tx with CLKS_PER_BIT=4, POLL_GAP=8.
//   A queue-based FIFO model feeds the DUT; expected line levels come from the
//   frame format (start 0, data LSB first, stop 1) applied to each byte.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int PG  = 8;

  logic       clk;
  logic       reset;
  logic       tx_enable;
  logic [7:0] fifo_data;
  logic       fifo_underflow;
  logic       fifo_rd_en;
  logic       tx;
  logic       tx_busy;
  logic       frame_done;
  logic       empty_seen;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int rd_count = 0;
  int exp_rd   = 0;
  logic rd_prev = 1'b0;

  // 0: normal, 1: underflow flag with stale nonzero data, 2: empty with data 0 only
  int uf_mode = 0;
  logic [7:0] q[$];

  fifo_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .POLL_GAP     (PG)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .tx_enable      (tx_enable),
    .fifo_data      (fifo_data),
    .fifo_underflow (fifo_underflow),
    .fifo_rd_en     (fifo_rd_en),
    .tx             (tx),
    .tx_busy        (tx_busy),
    .frame_done     (frame_done),
    .empty_seen     (empty_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // FIFO read port model: data valid the cycle after en_read.
  initial begin
    fifo_data      = 8'h00;
    fifo_underflow = 1'b0;
  end
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (uf_mode == 1) begin
        fifo_data      <= 8'h3C;
        fifo_underflow <= 1'b1;
      end else if (q.size() > 0) begin
        fifo_data      <= q.pop_front();
        fifo_underflow <= 1'b0;
      end else begin
        fifo_data      <= 8'h00;
        fifo_underflow <= (uf_mode == 2) ? 1'b0 : 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    assert (got === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  // Read-request monitor: counts pulses and rejects back-to-back requests.
  always @(negedge clk) begin
    if (fifo_rd_en) begin
      rd_count = rd_count + 1;
      chk("rd_en_back_to_back", {31'b0, rd_prev}, 32'd0);
    end
    rd_prev <= fifo_rd_en;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk($sformatf("idle_c%0d {tx,rd,busy,done,empty}", k),
          {tx, fifo_rd_en, tx_busy, frame_done, empty_seen}, 5'b10000);
    end
  endtask

  // Entered in the first START cycle. drop_bit: frame bit at which tx_enable
  // is released. abort_bit: frame bit at which reset is pulsed (-1 = none).
  task automatic check_frame(input logic [7:0] b, input int drop_bit, input int abort_bit);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < CPB; j++) begin
        chk($sformatf("frame_%02h_bit%0d_c%0d {tx,done,busy,rd}", b, i, j),
            {tx, frame_done, tx_busy, fifo_rd_en},
            {bits[i], ((i == 9) && (j == CPB - 1)), 1'b1, 1'b0});
        if ((i == abort_bit) && (j == 0)) begin
          reset = 1'b0;
          tick();
          chk($sformatf("abort_%02h {tx,busy,rd,done}", b),
              {tx, tx_busy, fifo_rd_en, frame_done}, 4'b1000);
          reset = 1'b1;
          $display("frame %02h aborted by reset at frame bit %0d", b, i);
          return;
        end
        if ((i == drop_bit) && (j == 0)) tx_enable = 1'b0;
        tick();
      end
    end
    $display("frame %02h sent", b);
  endtask

  // Entered in the REQ cycle.
  task automatic fetch_frame(input logic [7:0] b, input int drop_bit, input int abort_bit);
    chk("req {tx,rd,busy}", {tx, fifo_rd_en, tx_busy}, 3'b111);
    exp_rd = exp_rd + 1;
    tick();
    chk("cap {tx,rd,busy,empty}", {tx, fifo_rd_en, tx_busy, empty_seen}, 4'b1010);
    tick();
    check_frame(b, drop_bit, abort_bit);
  endtask

  initial begin
    logic [7:0] rnd[5];

    // 1. reset held low with tx_enable high
    reset     = 1'b0;
    tx_enable = 1'b1;
    q.push_back(8'hA5);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("reset_c%0d {tx,rd,busy,done,empty}", k),
          {tx, fifo_rd_en, tx_busy, frame_done, empty_seen}, 5'b10000);
    end

    // 2. single byte A5, 3-cycle latency, then back to idle
    reset = 1'b1;
    tick();
    fetch_frame(8'hA5, 0, -1);
    idle_check(12);

    // 3. two bytes streamed back to back
    q.push_back(8'h01);
    q.push_back(8'h80);
    tx_enable = 1'b1;
    tick();
    fetch_frame(8'h01, -1, -1);
    fetch_frame(8'h80, 0, -1);
    idle_check(4);

    // 4. empty reads: data 0 + underflow, stale data + underflow, data 0 alone
    tx_enable = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      uf_mode = r;
      chk($sformatf("empty_req%0d {tx,rd,busy}", r), {tx, fifo_rd_en, tx_busy}, 3'b111);
      exp_rd = exp_rd + 1;
      if (r == 2) tx_enable = 1'b0;
      tick();
      chk($sformatf("empty_cap%0d {tx,rd,busy,empty}", r),
          {tx, fifo_rd_en, tx_busy, empty_seen}, 4'b1011);
      $display("fetch %0d returned empty", r);
      if (r < 2) begin
        for (int k = 1; k <= PG + 1; k++) begin
          tick();
          chk($sformatf("poll%0d_c%0d {rd,tx,empty}", r, k),
              {fifo_rd_en, tx, empty_seen}, {(k == PG + 1), 1'b1, 1'b0});
        end
      end
    end
    uf_mode = 0;
    idle_check(12);

    // 5. tx_enable released during data bit 3 of FF
    q.push_back(8'hFF);
    tx_enable = 1'b1;
    tick();
    fetch_frame(8'hFF, 4, -1);
    idle_check(12);

    // 6. reset pulsed during data bit 5; next byte follows, aborted one is not resent
    q.push_back(8'hC3);
    q.push_back(8'h5A);
    tx_enable = 1'b1;
    tick();
    fetch_frame(8'hC3, -1, 6);
    tick();
    fetch_frame(8'h5A, 0, -1);
    idle_check(6);

    // 7. randomized bytes streamed
    foreach (rnd[i]) begin
      rnd[i] = 8'($urandom_range(1, 255));
      q.push_back(rnd[i]);
    end
    tx_enable = 1'b1;
    tick();
    foreach (rnd[i]) fetch_frame(rnd[i], (i == 4) ? 0 : -1, -1);
    idle_check(6);

    chk("rd_en_total", rd_count, exp_rd);
    chk("fifo_drained", q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
